// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store unit: bus widths, execute-info
// field positions, LSU state and access-size encodings, and small helpers
// for natural-alignment handling.
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When defined, misaligned
// half/word accesses raise misalign_o instead of being issued. When it is
// undefined, low address bits are masked to natural alignment.
package lsu_mem_ctrl_pkg;

  localparam int REG_BUS      = 32;
  localparam int MEM_ADDR_BUS = 32;
  localparam int REG_ADDR_BUS = 5;
  localparam int EXE_INFO_BUS = 5;

  // Bit positions of the memory-operation fields inside exe_info_bus_i
  localparam int EXE_MEM_RE      = 0;
  localparam int EXE_MEM_WE      = 1;
  localparam int EXE_MEM_SIZE_LO = 2;
  localparam int EXE_MEM_SIZE_HI = 3;
  localparam int EXE_MEM_UNS     = 4;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    MEM_SIZE_B = 2'b00,
    MEM_SIZE_H = 2'b01,
    MEM_SIZE_W = 2'b10
  } mem_size_e;

  // Byte offset inside the word after forcing natural alignment; the
  // unused size code 11 is handled as a word access
  function automatic logic [1:0] align_offset(input logic [1:0] size,
                                              input logic [1:0] addr_lo);
    logic [1:0] off;
    case (size)
      MEM_SIZE_B: off = addr_lo;
      MEM_SIZE_H: off = {addr_lo[1], 1'b0};
      default:    off = 2'b00;
    endcase
    return off;
  endfunction

  // True when a half or word access is not naturally aligned
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (size)
      MEM_SIZE_B: mis = 1'b0;
      MEM_SIZE_H: mis = addr_lo[0];
      default:    mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dff_lrc.sv
// Generic register with synchronous active-high reset, synchronous clear
// and load enable. Reset and clear both return the register to RST_VAL;
// reset has priority over clear, clear has priority over load.
module dff_lrc #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Register update: reset, then clear, then load
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (clr) begin
      q <= RST_VAL;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/lsu_align.sv
// Combinational data formatting for the LSU: store byte enables and lane
// replication, plus load lane extraction with sign or zero extension.
// The byte offset arriving here is already naturally aligned.
module lsu_align
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [1:0]         size,
  input  logic               uns,
  input  logic [1:0]         addr_lo,
  input  logic [REG_BUS-1:0] st_data,
  input  logic [REG_BUS-1:0] rdata,
  output logic [3:0]         be,
  output logic [REG_BUS-1:0] wdata,
  output logic [REG_BUS-1:0] ld_data
);

  logic [REG_BUS-1:0] shifted;

  // Store side: replicate the small operand to every lane so the byte
  // enables alone select where it lands in memory
  always_comb begin
    be    = 4'b1111;
    wdata = st_data;
    case (size)
      MEM_SIZE_B: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{st_data[7:0]}};
      end
      MEM_SIZE_H: begin
        be    = 4'b0011 << {addr_lo[1], 1'b0};
        wdata = {2{st_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = st_data;
      end
    endcase
  end

  // Load side: bring the addressed lane down to bit 0, then extend
  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    ld_data = shifted;
    case (size)
      MEM_SIZE_B: ld_data = uns ? {24'd0, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
      MEM_SIZE_H: ld_data = uns ? {16'd0, shifted[15:0]}
                                : {{16{shifted[15]}}, shifted[15:0]};
      default:    ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit behind the EX/LS pipeline register. Non-memory ops pass
// straight through to writeback; memory ops run a req/gnt/rvalid handshake
// on the data bus while holding a stall request, then present writeback in
// the DONE state. At most one transaction is ever outstanding.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap instead of masking
// misaligned half/word addresses).
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_we_i,
  input  logic [REG_BUS-1:0]      rd_mem_data_i,
  input  logic [REG_ADDR_BUS-1:0] rd_addr_i,
  input  logic [MEM_ADDR_BUS-1:0] mem_addr_i,
  input  logic [EXE_INFO_BUS-1:0] exe_info_bus_i,
  input  logic [5:0]              flush_i,
  output logic                    stall_req_o,
  output logic                    dbus_req_o,
  output logic                    dbus_we_o,
  output logic [MEM_ADDR_BUS-1:0] dbus_addr_o,
  output logic [3:0]              dbus_be_o,
  output logic [REG_BUS-1:0]      dbus_wdata_o,
  input  logic                    dbus_gnt_i,
  input  logic                    dbus_rvalid_i,
  input  logic [REG_BUS-1:0]      dbus_rdata_i,
  output logic                    rd_we_o,
  output logic [REG_ADDR_BUS-1:0] rd_addr_o,
  output logic [REG_BUS-1:0]      rd_wdata_o,
  output logic                    misalign_o
);

  logic               mem_re;
  logic               mem_we;
  logic [1:0]         mem_size;
  logic               mem_uns;
  logic               mem_op;
  logic               mem_go;
  logic               kill;
  logic               misaligned;
  logic [1:0]         addr_lo;
  logic [3:0]         fmt_be;
  logic [REG_BUS-1:0] fmt_wdata;
  logic [REG_BUS-1:0] fmt_ld_data;

  lsu_state_e         state_q;
  lsu_state_e         state_d;
  logic [1:0]         state_bits;
  logic               bus_req;
  logic               capture;
  logic               set_kill;
  logic               kill_q;
  logic [REG_BUS-1:0] ld_data_q;

  logic               flush_unused;

  assign mem_re   = exe_info_bus_i[EXE_MEM_RE];
  assign mem_we   = exe_info_bus_i[EXE_MEM_WE];
  assign mem_size = exe_info_bus_i[EXE_MEM_SIZE_HI:EXE_MEM_SIZE_LO];
  assign mem_uns  = exe_info_bus_i[EXE_MEM_UNS];
  assign mem_op   = mem_re | mem_we;
  assign kill     = flush_i[4];

  // Only the LS-stage flush bit concerns this unit
  assign flush_unused = ^{flush_i[5], flush_i[3:0]};

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = mem_op & is_misaligned(mem_size, mem_addr_i[1:0]);
  assign misalign_o = (state_q == LSU_IDLE) & misaligned & ~kill;
`else
  assign misaligned = 1'b0;
  assign misalign_o = 1'b0;
`endif

  // A trapped access never reaches the bus; masking the offset is harmless
  // in the trap build since only aligned accesses go out
  assign mem_go  = mem_op & ~misaligned;
  assign addr_lo = align_offset(mem_size, mem_addr_i[1:0]);

  lsu_align u_align (
    .size    (mem_size),
    .uns     (mem_uns),
    .addr_lo (addr_lo),
    .st_data (rd_mem_data_i),
    .rdata   (dbus_rdata_i),
    .be      (fmt_be),
    .wdata   (fmt_wdata),
    .ld_data (fmt_ld_data)
  );

  // Next-state logic: request from IDLE/REQ, absorb the response in WAIT
  always_comb begin
    state_d  = state_q;
    bus_req  = 1'b0;
    capture  = 1'b0;
    set_kill = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (mem_go && !kill) begin
          bus_req = 1'b1;
          state_d = dbus_gnt_i ? LSU_WAIT : LSU_REQ;
        end
      end
      LSU_REQ: begin
        if (kill || !mem_go) begin
          state_d = LSU_IDLE;
        end else begin
          bus_req = 1'b1;
          if (dbus_gnt_i) begin
            state_d = LSU_WAIT;
          end
        end
      end
      LSU_WAIT: begin
        set_kill = kill;
        if (dbus_rvalid_i) begin
          capture = 1'b1;
          state_d = LSU_DONE;
        end
      end
      LSU_DONE: begin
        state_d = LSU_IDLE;
      end
      default: begin
        state_d = LSU_IDLE;
      end
    endcase
  end

  dff_lrc #(.WIDTH(2), .RST_VAL(LSU_IDLE)) u_state_reg (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .ld  (1'b1),
    .d   (state_d),
    .q   (state_bits)
  );

  assign state_q = lsu_state_e'(state_bits);

  dff_lrc #(.WIDTH(REG_BUS)) u_ld_data_reg (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .ld  (capture),
    .d   (fmt_ld_data),
    .q   (ld_data_q)
  );

  // The kill mark lives only until the flushed access leaves DONE
  dff_lrc #(.WIDTH(1)) u_kill_reg (
    .clk (clk),
    .rst (rst),
    .clr (state_q == LSU_DONE),
    .ld  (set_kill),
    .d   (1'b1),
    .q   (kill_q)
  );

  // WAIT always stalls because the response must be absorbed even when
  // the instruction was flushed; IDLE/REQ stall exactly while requesting
  assign stall_req_o = (state_q == LSU_WAIT) | bus_req;

  // Bus fields are zero when idle so the port is quiet between accesses
  always_comb begin
    dbus_req_o   = bus_req;
    dbus_we_o    = bus_req & mem_we;
    dbus_addr_o  = '0;
    dbus_be_o    = '0;
    dbus_wdata_o = '0;
    if (bus_req) begin
      dbus_addr_o  = {mem_addr_i[MEM_ADDR_BUS-1:2], 2'b00};
      dbus_be_o    = fmt_be;
      dbus_wdata_o = fmt_wdata;
    end
  end

  // Writeback: pass-through for non-memory ops, load result in DONE
  always_comb begin
    rd_we_o    = 1'b0;
    rd_addr_o  = rd_addr_i;
    rd_wdata_o = '0;
    if (!mem_op) begin
      rd_we_o    = rd_we_i & ~kill;
      rd_wdata_o = rd_mem_data_i;
    end else if (state_q == LSU_DONE) begin
      rd_we_o    = mem_re & rd_we_i & ~kill_q & ~kill;
      rd_wdata_o = ld_data_q;
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl. Inputs change 1 time unit
// after the rising edge, outputs are sampled on the falling edge. Expected
// writebacks are queued as each access is driven and popped when the
// access reaches its completion cycle. Follows LSU_MISALIGN_TRAP_EN.
module tb_lsu_mem_ctrl;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_we_i;
  logic [31:0] rd_mem_data_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] mem_addr_i;
  logic [4:0]  exe_info_bus_i;
  logic [5:0]  flush_i;
  logic        stall_req_o;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_be_o;
  logic [31:0] dbus_wdata_o;
  logic        dbus_gnt_i;
  logic        dbus_rvalid_i;
  logic [31:0] dbus_rdata_i;
  logic        rd_we_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_wdata_o;
  logic        misalign_o;

  int  n_checks = 0;
  int  n_fail   = 0;
  wb_t sb_q[$];

  lsu_mem_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .rd_we_i        (rd_we_i),
    .rd_mem_data_i  (rd_mem_data_i),
    .rd_addr_i      (rd_addr_i),
    .mem_addr_i     (mem_addr_i),
    .exe_info_bus_i (exe_info_bus_i),
    .flush_i        (flush_i),
    .stall_req_o    (stall_req_o),
    .dbus_req_o     (dbus_req_o),
    .dbus_we_o      (dbus_we_o),
    .dbus_addr_o    (dbus_addr_o),
    .dbus_be_o      (dbus_be_o),
    .dbus_wdata_o   (dbus_wdata_o),
    .dbus_gnt_i     (dbus_gnt_i),
    .dbus_rvalid_i  (dbus_rvalid_i),
    .dbus_rdata_i   (dbus_rdata_i),
    .rd_we_o        (rd_we_o),
    .rd_addr_o      (rd_addr_o),
    .rd_wdata_o     (rd_wdata_o),
    .misalign_o     (misalign_o)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic driveIdle();
    rd_we_i        = 1'b0;
    rd_mem_data_i  = '0;
    rd_addr_i      = '0;
    mem_addr_i     = '0;
    exe_info_bus_i = '0;
    flush_i        = '0;
    dbus_gnt_i     = 1'b0;
    dbus_rvalid_i  = 1'b0;
    dbus_rdata_i   = '0;
  endtask

  // One complete memory access: gnt arrives gnt_dly cycles after the
  // request, rvalid rv_dly cycles after the cycle following gnt
  task automatic applyStimulus(
    input string       name,
    input logic        re,
    input logic        we,
    input logic [1:0]  size,
    input logic        uns,
    input logic [31:0] addr,
    input logic [31:0] st_data,
    input logic [4:0]  rd,
    input int          gnt_dly,
    input int          rv_dly,
    input logic [31:0] rdata,
    input logic        flush_wait,
    input logic [31:0] exp_addr,
    input logic [3:0]  exp_be,
    input logic [31:0] exp_wdata,
    input logic        exp_we,
    input logic [31:0] exp_data
  );
    int  g;
    int  r;
    int  d;
    wb_t e;
    g = gnt_dly;
    r = g + 1 + rv_dly;
    d = r + 1;
    e.we   = exp_we;
    e.addr = rd;
    e.data = exp_data;
    sb_q.push_back(e);
    rd_we_i        = re;
    rd_mem_data_i  = st_data;
    rd_addr_i      = rd;
    mem_addr_i     = addr;
    exe_info_bus_i = {uns, size, we, re};
    for (int c = 0; c <= d; c++) begin
      dbus_gnt_i    = (c == g);
      dbus_rvalid_i = (c == r);
      dbus_rdata_i  = (c == r) ? rdata : 32'h5A5A_5A5A;
      flush_i       = (flush_wait && c == g + 1) ? 6'b01_0000 : 6'b00_0000;
      @(negedge clk);
      if (c <= g) begin
        checkOutput({name, ":req"},   dbus_req_o,   1);
        checkOutput({name, ":we"},    dbus_we_o,    we);
        checkOutput({name, ":addr"},  dbus_addr_o,  exp_addr);
        checkOutput({name, ":be"},    dbus_be_o,    exp_be);
        checkOutput({name, ":wdata"}, dbus_wdata_o, exp_wdata);
      end else begin
        checkOutput({name, ":req_off"}, dbus_req_o, 0);
      end
      if (c < d) begin
        checkOutput({name, ":stall_busy"}, stall_req_o, 1);
        checkOutput({name, ":wb_quiet"},   rd_we_o,     0);
      end else begin
        checkOutput({name, ":stall_done"}, stall_req_o, 0);
        e = sb_q.pop_front();
        checkOutput({name, ":wb_we"},   rd_we_o,   e.we);
        checkOutput({name, ":wb_addr"}, rd_addr_o, e.addr);
        if (e.we) checkOutput({name, ":wb_data"}, rd_wdata_o, e.data);
      end
      @(posedge clk);
      #1;
    end
    driveIdle();
  endtask

  initial begin
    $display("[TB] lsu_mem_ctrl directed test start");
    rst = 1'b1;
    driveIdle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst:req",      dbus_req_o,   0);
    checkOutput("rst:stall",    stall_req_o,  0);
    checkOutput("rst:addr",     dbus_addr_o,  0);
    checkOutput("rst:be",       dbus_be_o,    0);
    checkOutput("rst:rd_we",    rd_we_o,      0);
    checkOutput("rst:rd_wdata", rd_wdata_o,   0);
    checkOutput("rst:misalign", misalign_o,   0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Non-memory op passes straight through without a stall
    rd_we_i       = 1'b1;
    rd_addr_i     = 5'd7;
    rd_mem_data_i = 32'h0000_0055;
    @(negedge clk);
    checkOutput("pass:we",    rd_we_o,     1);
    checkOutput("pass:addr",  rd_addr_o,   5'd7);
    checkOutput("pass:data",  rd_wdata_o,  32'h0000_0055);
    checkOutput("pass:stall", stall_req_o, 0);
    checkOutput("pass:req",   dbus_req_o,  0);
    @(posedge clk);
    #1;
    driveIdle();

    applyStimulus("lw_min", 1, 0, 2'b10, 0, 32'h100, 32'h0, 5'd1, 0, 0,
                  32'hDEAD_BEEF, 0, 32'h100, 4'b1111, 32'h0, 1, 32'hDEAD_BEEF);
    applyStimulus("lb", 1, 0, 2'b00, 0, 32'h103, 32'h0, 5'd2, 0, 0,
                  32'h8012_3456, 0, 32'h100, 4'b1000, 32'h0, 1, 32'hFFFF_FF80);
    applyStimulus("lbu", 1, 0, 2'b00, 1, 32'h103, 32'h0, 5'd3, 0, 0,
                  32'h8012_3456, 0, 32'h100, 4'b1000, 32'h0, 1, 32'h0000_0080);
    applyStimulus("sh", 0, 1, 2'b01, 0, 32'h102, 32'h1234_ABCD, 5'd0, 0, 0,
                  32'h0, 0, 32'h100, 4'b1100, 32'hABCD_ABCD, 0, 32'h0);
    applyStimulus("lw_gnt3", 1, 0, 2'b10, 0, 32'h208, 32'h0, 5'd4, 3, 0,
                  32'h1122_3344, 0, 32'h208, 4'b1111, 32'h0, 1, 32'h1122_3344);
    applyStimulus("lh_rv2", 1, 0, 2'b01, 0, 32'h102, 32'h0, 5'd5, 0, 2,
                  32'h8001_0000, 0, 32'h100, 4'b1100, 32'h0, 1, 32'hFFFF_8001);
    applyStimulus("lhu", 1, 0, 2'b01, 1, 32'h100, 32'h0, 5'd6, 1, 1,
                  32'h1234_F00F, 0, 32'h100, 4'b0011, 32'h0, 1, 32'h0000_F00F);
    applyStimulus("sb", 0, 1, 2'b00, 0, 32'h101, 32'h0000_00A5, 5'd0, 0, 0,
                  32'h0, 0, 32'h100, 4'b0010, 32'hA5A5_A5A5, 0, 32'h0);
    applyStimulus("lw_flush", 1, 0, 2'b10, 0, 32'h300, 32'h0, 5'd8, 0, 1,
                  32'h9999_9999, 1, 32'h300, 4'b1111, 32'h0, 0, 32'h0);
    applyStimulus("lw_after", 1, 0, 2'b10, 0, 32'h304, 32'h0, 5'd9, 0, 0,
                  32'h1234_5678, 0, 32'h304, 4'b1111, 32'h0, 1, 32'h1234_5678);

`ifdef LSU_MISALIGN_TRAP_EN
    rd_we_i        = 1'b1;
    rd_addr_i      = 5'd10;
    mem_addr_i     = 32'h101;
    exe_info_bus_i = {1'b0, 2'b10, 1'b0, 1'b1};
    @(negedge clk);
    checkOutput("mis:trap",  misalign_o,  1);
    checkOutput("mis:req",   dbus_req_o,  0);
    checkOutput("mis:stall", stall_req_o, 0);
    checkOutput("mis:wb",    rd_we_o,     0);
    @(posedge clk);
    #1;
    driveIdle();
`else
    applyStimulus("lw_mask", 1, 0, 2'b10, 0, 32'h101, 32'h0, 5'd10, 0, 0,
                  32'hA1B2_C3D4, 0, 32'h100, 4'b1111, 32'h0, 1, 32'hA1B2_C3D4);
    checkOutput("mask:misalign", misalign_o, 0);
`endif

    // Reset while waiting for a response; the late response is ignored
    rd_we_i        = 1'b1;
    rd_addr_i      = 5'd11;
    mem_addr_i     = 32'h400;
    exe_info_bus_i = {1'b0, 2'b10, 1'b0, 1'b1};
    dbus_gnt_i     = 1'b1;
    @(negedge clk);
    checkOutput("rstw:req", dbus_req_o, 1);
    @(posedge clk);
    #1;
    driveIdle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    dbus_rvalid_i = 1'b1;
    dbus_rdata_i  = 32'hFFFF_FFFF;
    @(negedge clk);
    checkOutput("rstw:stall", stall_req_o, 0);
    checkOutput("rstw:wb",    rd_we_o,     0);
    checkOutput("rstw:req0",  dbus_req_o,  0);
    @(posedge clk);
    #1;
    driveIdle();
    applyStimulus("lw_post_rst", 1, 0, 2'b10, 0, 32'h500, 32'h0, 5'd12, 0, 0,
                  32'h0BAD_CAFE, 0, 32'h500, 4'b1111, 32'h0, 1, 32'h0BAD_CAFE);

    checkOutput("sb:empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
